// File: rtl/if_id_queue.sv
// if_id_queue: instruction buffer between the I-cache fetch port and decode.
// Circular storage of {fault, pc, ins} with first-word fall-through output.
// Optional zero-latency bypass for an empty queue: define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int          DEPTH   = 4,
  parameter int          PTR_W   = 2,
  parameter logic [31:0] NOP_INS = 32'h00000013
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             FETCH_VALID,
  input  logic [31:0]      FETCH_INS,
  input  logic [63:0]      FETCH_PC,
  input  logic             FETCH_FAULT,
  output logic             FETCH_READY,
  input  logic             DECODE_STALL,
  output logic [31:0]      INSTRUCTION,
  output logic [63:0]      PC_OUT,
  output logic             FAULT_OUT,
  output logic             INS_VALID,
  output logic [PTR_W:0]   COUNT
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam int             ENT_W    = 97;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             empty;
  logic             push;
  logic             pop;
  logic             bypass_take;
  logic             bypass_consume;
  logic [ENT_W-1:0] rd_word;

  assign empty       = (count_q == '0);
  assign FETCH_READY = (count_q != FULL_CNT);
  assign COUNT       = count_q;
  assign rd_word     = mem_q[rp_q];

`ifdef IF_ID_QUEUE_BYPASS_EN
  // An empty queue forwards the fetch word straight to decode; if decode
  // takes it this cycle it never needs to be stored.
  assign bypass_take    = empty & FETCH_VALID & ~FLUSH;
  assign bypass_consume = bypass_take & ~DECODE_STALL;
`else
  assign bypass_take    = 1'b0;
  assign bypass_consume = 1'b0;
`endif

  // Pops only ever come from stored entries; a bypassed word is not in storage.
  assign push = FETCH_VALID & FETCH_READY & ~FLUSH & ~bypass_consume;
  assign pop  = ~empty & ~DECODE_STALL & ~FLUSH;

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (FLUSH) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_W'(1);
      if (pop)  rp_d = rp_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers; reset empties the queue immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset because occupancy gates the output.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= {FETCH_FAULT, FETCH_PC, FETCH_INS};
  end

  // Output select: head entry, bypassed fetch word, or a NOP bubble.
  always_comb begin
    INS_VALID   = 1'b0;
    INSTRUCTION = NOP_INS;
    PC_OUT      = '0;
    FAULT_OUT   = 1'b0;
    if (!empty) begin
      INS_VALID   = 1'b1;
      FAULT_OUT   = rd_word[96];
      PC_OUT      = rd_word[95:32];
      INSTRUCTION = rd_word[31:0];
    end else if (bypass_take) begin
      INS_VALID   = 1'b1;
      FAULT_OUT   = FETCH_FAULT;
      PC_OUT      = FETCH_PC;
      INSTRUCTION = FETCH_INS;
    end
  end

endmodule
